univ_shift_reg: RTL

- Parametrised successor to the single-bit enable/reset D flip-flop: a WIDTH-bit register with enable, synchronous clear and a mode-selected next-state function.
- Modes: hold, parallel load, logical shift, rotate and arithmetic shift.
- A saturating shift counter and a completion pulse support serialiser use.
- Sits in the sequential-circuit library as the general storage/serialiser primitive for datapath and SPI/UART-style blocks.

---
 rtl/shift_pkg.sv | 64 ++++++
 rtl/sat_counter.sv | 46 ++++
 rtl/univ_shift_reg.sv | 79 +++++++
 3 files changed

// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_pkg
//  Description : Mode encodings and next-state helper for univ_shift_reg.
//  Revision    : 1.0 - initial release
// ============================================================================
package shift_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_RSVD = 3'b111;

    // Widest register the helper supports; callers zero-extend into this.
    localparam int MAX_W = 64;

    function automatic logic is_shift(input logic [2:0] mode);
        return (mode >= MODE_SHL) && (mode <= MODE_ASR);
    endfunction

    // Operands must be zero-extended above bit width-1; only the low
    // width bits of the result are meaningful.
    function automatic logic [MAX_W-1:0] next_q(
        input logic [2:0]       mode,
        input logic [MAX_W-1:0] q,
        input logic [MAX_W-1:0] d,
        input logic             ser_in,
        input int unsigned      width
    );
        logic [MAX_W-1:0] r;
        r = q;
        case (mode)
            MODE_LOAD: r = d;
            MODE_SHL: begin
                r    = q << 1;
                r[0] = ser_in;
            end
            MODE_SHR: begin
                r            = q >> 1;
                r[width-1]   = ser_in;
            end
            MODE_ROL: begin
                r    = q << 1;
                r[0] = q[width-1];
            end
            MODE_ROR: begin
                r            = q >> 1;
                r[width-1]   = q[0];
            end
            MODE_ASR: begin
                r            = q >> 1;
                r[width-1]   = q[width-1];
            end
            default: r = q;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Saturating up-counter with a registered pulse on reaching MAX.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 4,
    parameter int MAX   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             hit
);

    localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX);

    logic [CNT_W-1:0] r_cnt;
    logic             r_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_hit <= 1'b0;
        end else if (clr) begin
            r_cnt <= '0;
            r_hit <= 1'b0;
        end else if (inc) begin
            if (r_cnt != C_MAX) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            // Only the MAX-1 -> MAX transition pulses; sitting at MAX does not.
            r_hit <= (r_cnt == C_MAX - CNT_W'(1));
        end else begin
            r_hit <= 1'b0;
        end
    end

    assign cnt = r_cnt;
    assign hit = r_hit;

endmodule
`default_nettype wire

// File: rtl/univ_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module      : univ_shift_reg
//  Description : WIDTH-bit universal shift register with shift counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module univ_shift_reg
    import shift_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic             sout_msb,
    output logic             sout_lsb,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             full_shift
);

    generate
        if (WIDTH < 2 || WIDTH > MAX_W) begin : g_bad_width
            $error("univ_shift_reg: WIDTH must be between 2 and %0d", MAX_W);
        end
    endgenerate

    logic [WIDTH-1:0] r_q;
    logic [MAX_W-1:0] w_wide;
    logic [WIDTH-1:0] w_next;
    logic             w_inc;
    logic             w_cnt_clr;
    logic             w_unused;

    always_comb begin
        w_wide = next_q(mode, MAX_W'(r_q), MAX_W'(d), ser_in, WIDTH);
    end

    assign w_next   = w_wide[WIDTH-1:0];
    assign w_unused = ^w_wide;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= RESET_VAL;
        end else if (clr) begin
            r_q <= RESET_VAL;
        end else if (en) begin
            r_q <= w_next;
        end
    end

    // A parallel load restarts the serialisation count.
    assign w_inc     = en && !clr && is_shift(mode);
    assign w_cnt_clr = clr || (en && (mode == MODE_LOAD));

    sat_counter #(
        .CNT_W (CNT_W),
        .MAX   (WIDTH)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (w_cnt_clr),
        .inc   (w_inc),
        .cnt   (shift_cnt),
        .hit   (full_shift)
    );

    assign q        = r_q;
    assign sout_msb = r_q[WIDTH-1];
    assign sout_lsb = r_q[0];

endmodule
`default_nettype wire
